// File: rtl/cpu_pkg.sv
// Shared definitions for the 18-bit CPU: widths, opcode field, fetch states.
package cpu_pkg;

   localparam int          CPU_ADDR_W      = 10;
   localparam int          CPU_INSTR_W     = 18;
   localparam int          CPU_OPC_HI      = 17;
   localparam int          CPU_OPC_LO      = 14;
   localparam logic [3:0]  CPU_HALT_OPCODE = 4'b1111;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, imem addressing, single-entry valid/ready output
// slot, branch/jump redirect. HALT-opcode stopping is built only when the
// IFETCH_HALT_EN macro is defined; otherwise halted is 0 and resume is ignored.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W      = CPU_ADDR_W,
   parameter int                INSTR_W     = CPU_INSTR_W,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   parameter logic [3:0]        HALT_OPCODE = CPU_HALT_OPCODE
) (
   input  logic               clk,
   input  logic               reset,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic               halted,
   input  logic               resume
);

   fetch_state_t        r_state;
   fetch_state_t        w_state_nxt;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_nxt;
   logic                r_out_valid;
   logic [INSTR_W-1:0]  r_out_instr;
   logic [ADDR_W-1:0]   r_out_pc;
   logic                w_load;
   logic                w_is_halt;
   logic                w_resume;

   // A redirect squashes any load in the same cycle; the slot must be free or draining.
   assign w_load = (r_state == ST_RUN) && (!r_out_valid || out_ready) && !redirect_valid;

`ifdef IFETCH_HALT_EN
   assign w_is_halt = w_load && (imem_data[CPU_OPC_HI:CPU_OPC_LO] == HALT_OPCODE);
   assign w_resume  = (r_state == ST_HALTED) && resume;
`else
   logic w_unused;
   assign w_is_halt = 1'b0;
   assign w_resume  = 1'b0;
   assign w_unused  = ^{resume, HALT_OPCODE};
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_BOOT;
      else        r_state <= w_state_nxt;
   end

   // Next-state: redirect always lands in RUN; BOOT lasts exactly one cycle
   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid) begin
         w_state_nxt = ST_RUN;
      end else begin
         case (r_state)
            ST_BOOT:   w_state_nxt = ST_RUN;
            ST_RUN:    if (w_is_halt) w_state_nxt = ST_HALTED;
            ST_HALTED: if (w_resume)  w_state_nxt = ST_RUN;
            default:   w_state_nxt = ST_BOOT;
         endcase
      end
   end

   // Outputs derived from state: halted is a function of the state register only
   always_comb begin
      halted = 1'b0;
`ifdef IFETCH_HALT_EN
      halted = (r_state == ST_HALTED);
`endif
   end

   // Next-PC mux: redirect > sequential load (held on HALT) > resume step
   always_comb begin
      w_pc_nxt = r_pc;
      if (redirect_valid)                w_pc_nxt = redirect_pc;
      else if (w_load && !w_is_halt)     w_pc_nxt = r_pc + 1'b1;
      else if (w_resume)                 w_pc_nxt = r_pc + 1'b1;
   end

   // PC register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_pc <= RESET_PC;
      else        r_pc <= w_pc_nxt;
   end

   // Output slot: redirect empties it, load refills it, transfer drains it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out_valid <= 1'b0;
         r_out_instr <= '0;
         r_out_pc    <= '0;
      end else if (redirect_valid) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_instr <= imem_data;
         r_out_pc    <= r_pc;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign imem_addr = r_pc;
   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_pc    = r_out_pc;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage feeding the decode/control path of the 18-bit CPU. Owns the 10-bit program counter, addresses the combinational instruction memory, and registers each fetched word with its PC into a single-entry output slot consumed by decode through a valid/ready handshake. Accepts branch/jump redirects from the control unit and optionally stops on a HALT opcode.

## Interface
Parameters:
- ADDR_W, 10, PC / instruction-memory address width
- INSTR_W, 18, instruction width
- RESET_PC, 0, PC value loaded at reset
- HALT_OPCODE, 4'b1111, opcode in instr[17:14] that halts fetch (IFETCH_HALT_EN only)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  instruction memory address
- imem_data  in  INSTR_W  instruction memory read data, same cycle as imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  ADDR_W  target PC for redirect
- out_valid  out  1  output slot holds a valid instruction
- out_ready  in  1  decode accepts slot this cycle
- out_instr  out  INSTR_W  fetched instruction
- out_pc  out  ADDR_W  address of out_instr
- halted  out  1  fetch stopped on HALT
- resume  in  1  leave HALTED, continue at pc+1

## Operation
- States: BOOT, RUN, HALTED. Reset enters BOOT; BOOT -> RUN unconditionally after one cycle, no fetch in BOOT.
- imem_addr = pc register, combinational.
- Transfer: out_valid && out_ready at a rising edge; slot then empty unless refilled that same edge.
- Load condition (RUN only): !out_valid || out_ready. On load: out_instr <= imem_data, out_pc <= pc, out_valid <= 1, pc <= pc + 1 modulo 2^ADDR_W (1023 -> 0).
- Stall: RUN, out_valid && !out_ready -> pc, out_instr, out_pc, out_valid held.
- Redirect (any state incl. BOOT): pc <= redirect_pc, out_valid <= 0, no load this cycle, state <= RUN. A transfer coinciding with redirect still completes (decode took the old word); slot still ends empty.
- HALT (loaded word has instr[17:14] == HALT_OPCODE): word delivered normally, pc <= pc (not incremented), state <= HALTED.
- HALTED: no loads; slot drains on transfer; halted = 1. resume -> pc <= pc + 1, state <= RUN, load resumes next cycle. Redirect and resume together: redirect wins.
- Reset mid-operation: all state discarded immediately, asynchronously.

## Timing
- Reset values: pc = RESET_PC, out_valid = 0, out_instr = 0, out_pc = 0, halted = 0, state = BOOT; imem_addr = RESET_PC.
- First out_valid = 1 two edges after reset deassertion (BOOT edge, then load edge).
- Latency imem_data -> out_instr: one edge. Throughput: one instruction/cycle with out_ready held high.
- Redirect: redirect_pc appears on imem_addr the cycle after the redirect edge; its word on out_instr one edge later (2-cycle bubble).
- halted is registered; asserts the cycle after HALT word loads.
- Outputs depend only on registers; out_ready/redirect_valid have no combinational path to outputs.

## Configuration
- IFETCH_HALT_EN defined: HALT detection, HALTED state, halted and resume as above.
- Undefined: HALT_OPCODE is an ordinary instruction, HALTED unreachable, halted tied 0, resume ignored.

## Structure
- Shared package cpu_pkg: ADDR_W, INSTR_W, opcode field bounds [17:14], HALT_OPCODE, fetch state encoding (BOOT/RUN/HALTED).
- Flat module; next-PC mux and output slot inline, no sub-module required.

## Test plan
- Reset low then high, out_ready = 1, imem[0..3] = 0x00001..0x00004 -> out_valid rises on 2nd edge, out_pc 0,1,2,3 with matching out_instr on consecutive cycles.
- out_ready = 0 for 3 cycles while out_pc = 5 -> out_pc/out_instr hold at 5, imem_addr holds 6; out_ready = 1 -> 6 follows next cycle, no word lost or duplicated.
- pc at 1023, out_ready = 1 -> out_pc 1023 then 0 (wrap).
- redirect_valid with redirect_pc = 300 while out_pc = 10 valid, out_ready = 1 -> out_valid 0 next cycle, then out_pc = 300; address 11 never delivered.
- IFETCH_HALT_EN, imem[7] = 18'h3C000 -> out_pc 7 delivered, halted = 1, imem_addr stays 7; resume -> out_pc 8 delivered next load, halted = 0.
- Reset asserted while stalled with out_valid = 1 -> out_valid, halted drop immediately, pc = RESET_PC.
